// File: rtl/fwd_hazard_unit_n.sv
// EX-stage operand forwarding with per-port MEM/WB selects and a shared hold FSM.
// Also detects load-use hazards, drives stall/flush, and counts load-use stalls.
module fwd_hazard_unit_n #(
    parameter int WIDTH   = 32,
    parameter int NPORTS  = 2,
    parameter int REGBITS = 5,
    parameter int CNTW    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NPORTS*REGBITS-1:0] SrcRegD,
    input  logic [NPORTS*REGBITS-1:0] SrcRegE,
    input  logic [NPORTS*WIDTH-1:0]   RDE,
    input  logic [REGBITS-1:0]        WriteRegE,
    input  logic                      RegWriteE,
    input  logic                      MemtoRegE,
    input  logic [REGBITS-1:0]        WriteRegM,
    input  logic                      RegWriteM,
    input  logic [WIDTH-1:0]          ALUOutM,
    input  logic [REGBITS-1:0]        WriteRegW,
    input  logic                      RegWriteW,
    input  logic [WIDTH-1:0]          ResultW,
    input  logic                      HoldE,
    output logic [NPORTS*WIDTH-1:0]   SrcE,
    output logic [NPORTS*2-1:0]       ForwardE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      FlushE,
    output logic [CNTW-1:0]           LuStallCnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                    state;
    logic [NPORTS*WIDTH-1:0]   live;
    logic [NPORTS*WIDTH-1:0]   hold_reg;
    logic                      d_hit;
    logic                      lwstall;

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        logic [REGBITS-1:0] src_e;
        logic               mem_hit;
        logic               wb_hit;

        assign src_e   = SrcRegE[i*REGBITS +: REGBITS];
        assign mem_hit = RegWriteM && (WriteRegM != '0)
                         && (WriteRegM == src_e);
        assign wb_hit  = RegWriteW && (WriteRegW != '0)
                         && (WriteRegW == src_e);

        assign live[i*WIDTH +: WIDTH] =
            mem_hit ? ALUOutM :
            wb_hit  ? ResultW :
                      RDE[i*WIDTH +: WIDTH];

        assign SrcE[i*WIDTH +: WIDTH] =
            (state == HOLD) ? hold_reg[i*WIDTH +: WIDTH]
                            : live[i*WIDTH +: WIDTH];

        assign ForwardE[i*2 +: 2] =
            (state == HOLD) ? 2'b11 :
            mem_hit         ? 2'b10 :
            wb_hit          ? 2'b01 :
                              2'b00;
    end

    // Any ID-stage source reading the register an EX-stage load is writing.
    always_comb begin
        d_hit = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (SrcRegD[i*REGBITS +: REGBITS] == WriteRegE) begin
                d_hit = 1'b1;
            end
        end
    end

    assign lwstall = MemtoRegE && RegWriteE && (WriteRegE != '0) && d_hit;
    assign StallF  = lwstall | HoldE;
    assign StallD  = lwstall | HoldE;
    // A held instruction must survive, so never flush while holding.
    assign FlushE  = lwstall & ~HoldE;

    // Hold FSM: snapshot live operands on entry, release one cycle after HoldE drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold_reg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (HoldE) begin
                        hold_reg <= live;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (!HoldE) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating count of cycles in which a load-use bubble was inserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            LuStallCnt <= '0;
        end else if (FlushE && (LuStallCnt != {CNTW{1'b1}})) begin
            LuStallCnt <= LuStallCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit_n.sv
// Directed-vector bench for fwd_hazard_unit_n.
// A second instance with a 4-bit counter exercises saturation.
module tb_fwd_hazard_unit_n;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  SrcRegD;
    logic [9:0]  SrcRegE;
    logic [63:0] RDE;
    logic [4:0]  WriteRegE;
    logic        RegWriteE;
    logic        MemtoRegE;
    logic [4:0]  WriteRegM;
    logic        RegWriteM;
    logic [31:0] ALUOutM;
    logic [4:0]  WriteRegW;
    logic        RegWriteW;
    logic [31:0] ResultW;
    logic        HoldE;

    logic [63:0] SrcE;
    logic [3:0]  ForwardE;
    logic        StallF, StallD, FlushE;
    logic [15:0] LuStallCnt;

    logic [63:0] SrcE_s;
    logic [3:0]  ForwardE_s;
    logic        StallF_s, StallD_s, FlushE_s;
    logic [3:0]  LuStallCnt_s;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_n dut (
        .clk(clk), .reset(reset),
        .SrcRegD(SrcRegD), .SrcRegE(SrcRegE), .RDE(RDE),
        .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
        .ALUOutM(ALUOutM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .ResultW(ResultW), .HoldE(HoldE),
        .SrcE(SrcE), .ForwardE(ForwardE),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .LuStallCnt(LuStallCnt)
    );

    fwd_hazard_unit_n #(.CNTW(4)) dut_s (
        .clk(clk), .reset(reset),
        .SrcRegD(SrcRegD), .SrcRegE(SrcRegE), .RDE(RDE),
        .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
        .ALUOutM(ALUOutM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .ResultW(ResultW), .HoldE(HoldE),
        .SrcE(SrcE_s), .ForwardE(ForwardE_s),
        .StallF(StallF_s), .StallD(StallD_s), .FlushE(FlushE_s),
        .LuStallCnt(LuStallCnt_s)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        SrcRegD   = '0;
        SrcRegE   = {5'd2, 5'd1};
        RDE       = {32'h2222_0002, 32'h1111_0001};
        WriteRegE = '0;
        RegWriteE = 1'b0;
        MemtoRegE = 1'b0;
        WriteRegM = '0;
        RegWriteM = 1'b0;
        ALUOutM   = '0;
        WriteRegW = '0;
        RegWriteW = 1'b0;
        ResultW   = '0;
        HoldE     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_cnt",   LuStallCnt, 16'd0);
        check("rst_srce",  SrcE, RDE);
        check("rst_fwd",   ForwardE, 4'b0000);
        check("rst_stall", {StallF, StallD}, 2'b00);
        check("rst_flush", FlushE, 1'b0);

        // MEM beats WB on the same register
        SrcRegE   = {5'd2, 5'd3};
        WriteRegM = 5'd3; RegWriteM = 1'b1; ALUOutM = 32'hAAAA_0001;
        WriteRegW = 5'd3; RegWriteW = 1'b1; ResultW = 32'h0000_5555;
        #1;
        check("prio_mem_src", SrcE[31:0], 32'hAAAA_0001);
        check("prio_mem_fwd", ForwardE[1:0], 2'b10);
        check("prio_p1_src",  SrcE[63:32], 32'h2222_0002);
        check("prio_p1_fwd",  ForwardE[3:2], 2'b00);
        RegWriteM = 1'b0;
        #1;
        check("prio_wb_src", SrcE[31:0], 32'h0000_5555);
        check("prio_wb_fwd", ForwardE[1:0], 2'b01);

        // Independent ports: port0 from MEM, port1 from WB
        SrcRegE   = {5'd4, 5'd3};
        RegWriteM = 1'b1; WriteRegW = 5'd4;
        #1;
        check("indep_p0", SrcE[31:0], 32'hAAAA_0001);
        check("indep_p1", SrcE[63:32], 32'h0000_5555);
        check("indep_fwd", ForwardE, 4'b0110);

        // Register zero is never forwarded
        SrcRegE   = {5'd0, 5'd1};
        WriteRegM = 5'd0; RegWriteM = 1'b1;
        WriteRegW = 5'd0; RegWriteW = 1'b1;
        RDE[63:32] = 32'h0000_1234;
        #1;
        check("r0_src", SrcE[63:32], 32'h0000_1234);
        check("r0_fwd", ForwardE[3:2], 2'b00);
        RegWriteM = 1'b0; RegWriteW = 1'b0;

        // Load-use on port 1
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd7;
        SrcRegD   = {5'd7, 5'd0};
        #1;
        check("lu_stall", {StallF, StallD, FlushE}, 3'b111);
        tick();
        check("lu_cnt1", LuStallCnt, 16'd1);
        WriteRegE = 5'd0;
        SrcRegD   = '0;
        #1;
        check("lu_r0_stall", {StallF, StallD, FlushE}, 3'b000);
        tick();
        check("lu_r0_cnt", LuStallCnt, 16'd1);

        // Hold capture with a concurrent load-use hazard
        SrcRegE   = {5'd2, 5'd3};
        WriteRegM = 5'd3; RegWriteM = 1'b1; ALUOutM = 32'hDEAD_0000;
        WriteRegE = 5'd7; SrcRegD = {5'd0, 5'd7};
        HoldE     = 1'b1;
        #1;
        check("hold_c0_src", SrcE[31:0], 32'hDEAD_0000);
        check("hold_c0_fwd", ForwardE[1:0], 2'b10);
        check("hold_c0_stall", {StallF, StallD, FlushE}, 3'b110);
        tick();
        ALUOutM = 32'h0;
        #1;
        check("hold_c1_src", SrcE[31:0], 32'hDEAD_0000);
        check("hold_c1_fwd", ForwardE, 4'b1111);
        tick();
        check("hold_c2_src", SrcE[31:0], 32'hDEAD_0000);
        check("hold_c2_flush", FlushE, 1'b0);
        tick();
        HoldE = 1'b0; MemtoRegE = 1'b0;
        #1;
        check("hold_c3_src", SrcE[31:0], 32'hDEAD_0000);
        check("hold_c3_fwd", ForwardE[1:0], 2'b11);
        check("hold_c3_stall", StallF, 1'b0);
        tick();
        check("hold_c4_src", SrcE[31:0], 32'h0);
        check("hold_c4_fwd", ForwardE[1:0], 2'b10);
        check("hold_cnt", LuStallCnt, 16'd1);

        // Reset while holding
        ALUOutM = 32'hCAFE_0000;
        HoldE   = 1'b1;
        tick();
        ALUOutM = 32'h0000_0001;
        #1;
        check("rh_held", SrcE[31:0], 32'hCAFE_0000);
        reset = 1'b1;
        tick();
        reset = 1'b0; HoldE = 1'b0;
        #1;
        check("rh_live", SrcE[31:0], 32'h0000_0001);
        check("rh_fwd", ForwardE[1:0], 2'b10);
        check("rh_cnt", LuStallCnt, 16'd0);

        // Saturation on the 4-bit counter instance
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd7;
        SrcRegD   = {5'd0, 5'd7};
        for (int i = 0; i < 15; i++) tick();
        check("sat_15", LuStallCnt_s, 4'd15);
        for (int i = 0; i < 5; i++) tick();
        check("sat_20", LuStallCnt_s, 4'd15);
        check("wide_20", LuStallCnt, 16'd20);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
